// File: rtl/dmem_model_pkg.sv
// Shared types and helpers for the data-memory shadow model.
// Slot state is sized for the widest supported XLEN (64).
package dmem_model_pkg;

    localparam int XLEN_MAX = 64;
    localparam int NB_MAX   = XLEN_MAX / 8;

    typedef struct packed {
        logic [XLEN_MAX-1:0] data;
        logic [NB_MAX-1:0]   known;
    } slot_state_t;

    function automatic int nbytes(input int xlen);
        return xlen / 8;
    endfunction

    function automatic logic [XLEN_MAX-1:0] byte_merge(
        input logic [XLEN_MAX-1:0] old_d,
        input logic [XLEN_MAX-1:0] new_d,
        input logic [NB_MAX-1:0]   strb
    );
        logic [XLEN_MAX-1:0] r;
        r = old_d;
        for (int b = 0; b < NB_MAX; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_shadow_slot.sv
// One tracked word: address compare, byte-merged data and known mask.
// Bits above XLEN in the shared state type stay zero.
module dmem_shadow_slot
    import dmem_model_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [XLEN-1:0]         i_addr,
    input  logic [XLEN-1:0]         i_slot_addr,
    input  logic                    i_we,
    input  logic [XLEN-1:0]         i_wdata,
    input  logic [nbytes(XLEN)-1:0] i_wstrb,
    output logic                    o_hit,
    output logic [XLEN-1:0]         o_data,
    output logic [nbytes(XLEN)-1:0] o_known
);

    localparam int NB = nbytes(XLEN);

    slot_state_t         r_state;
    logic [XLEN_MAX-1:0] w_wdata_ext;
    logic [NB_MAX-1:0]   w_wstrb_ext;
    logic                w_unused;

    assign w_unused = ^{i_addr[1:0], i_slot_addr[1:0]};
    assign o_hit    = i_addr[XLEN-1:2] == i_slot_addr[XLEN-1:2];
    assign o_data   = r_state.data[XLEN-1:0];
    assign o_known  = r_state.known[NB-1:0];

    // Widen write data and strobes to the shared state width.
    always_comb begin
        w_wdata_ext = '0;
        w_wstrb_ext = '0;
        w_wdata_ext[XLEN-1:0] = i_wdata;
        w_wstrb_ext[NB-1:0]   = i_wstrb;
    end

    // Merge strobed bytes on a hitting write and mark them known.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= '0;
        end else if (i_we && o_hit) begin
            r_state.data  <= byte_merge(r_state.data, w_wdata_ext,
                                        w_wstrb_ext);
            r_state.known <= r_state.known | w_wstrb_ext;
        end
    end

endmodule

// File: rtl/dmem_shadow_model.sv
// Memory environment model: bounded wait states, shadow reads,
// sticky handshake-protocol error flags.
module dmem_shadow_model
    import dmem_model_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NSLOTS      = 2,
    parameter int MAX_WAIT    = 4,
    parameter int TRACK_INSTR = 1
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [NSLOTS*XLEN-1:0]  slot_addr,
    input  logic                    stall_req,
    input  logic [XLEN-1:0]         free_rdata,
    input  logic                    mem_valid,
    input  logic                    mem_instr,
    input  logic [XLEN-1:0]         mem_addr,
    input  logic [XLEN-1:0]         mem_wdata,
    input  logic [nbytes(XLEN)-1:0] mem_wstrb,
    output logic                    mem_ready,
    output logic [XLEN-1:0]         mem_rdata,
    output logic                    err_unstable,
    output logic                    err_timeout
);

    localparam int NB  = nbytes(XLEN);
    localparam int WCW = $clog2(MAX_WAIT + 2);
    localparam logic [WCW-1:0] MAXW = WCW'(MAX_WAIT);

    logic [WCW-1:0]  r_wait;
    logic            r_pend;
    logic            r_snap_instr;
    logic [XLEN-1:0] r_snap_addr;
    logic [XLEN-1:0] r_snap_wdata;
    logic [NB-1:0]   r_snap_wstrb;

    logic            w_stall;
    logic            w_hs;
    logic            w_wr;
    logic            w_use_shadow;
    logic            w_changed;
    logic [NSLOTS-1:0] w_hit;
    logic [XLEN-1:0] w_sdata  [NSLOTS];
    logic [NB-1:0]   w_sknown [NSLOTS];
    logic [XLEN-1:0] w_sel_data;
    logic [NB-1:0]   w_sel_known;
    logic [XLEN-1:0] w_rdata;

    assign mem_ready = resetn && mem_valid
                       && (!stall_req || r_wait == MAXW);
    assign w_stall   = mem_valid && !mem_ready;
    assign w_hs      = mem_valid && mem_ready;
    assign w_wr      = w_hs && (mem_wstrb != '0);
    assign w_use_shadow = (TRACK_INSTR != 0) || !mem_instr;
    assign w_changed = !mem_valid
                       || mem_instr != r_snap_instr
                       || mem_addr  != r_snap_addr
                       || mem_wdata != r_snap_wdata
                       || mem_wstrb != r_snap_wstrb;
    assign mem_rdata = resetn ? w_rdata : '0;

    for (genvar i = 0; i < NSLOTS; i++) begin : g_slot
        dmem_shadow_slot #(.XLEN(XLEN)) u_slot (
            .i_clk       (clock),
            .i_rst_n     (resetn),
            .i_addr      (mem_addr),
            .i_slot_addr (slot_addr[i*XLEN +: XLEN]),
            .i_we        (w_wr),
            .i_wdata     (mem_wdata),
            .i_wstrb     (mem_wstrb),
            .o_hit       (w_hit[i]),
            .o_data      (w_sdata[i]),
            .o_known     (w_sknown[i])
        );
    end

    // Lowest-index hitting slot sources reads; unknown bytes are free.
    always_comb begin
        w_sel_data  = '0;
        w_sel_known = '0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel_data  = w_sdata[i];
                w_sel_known = w_sknown[i];
            end
        end
        w_rdata = free_rdata;
        for (int b = 0; b < NB; b++) begin
            if (w_use_shadow && w_sel_known[b])
                w_rdata[b*8 +: 8] = w_sel_data[b*8 +: 8];
        end
    end

    // Consecutive stall counter; saturates where ready is forced.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wait <= '0;
        end else if (!w_stall) begin
            r_wait <= '0;
        end else if (r_wait != MAXW) begin
            r_wait <= r_wait + WCW'(1);
        end
    end

    // Pending flag and request snapshot taken when a stall begins.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pend       <= 1'b0;
            r_snap_instr <= 1'b0;
            r_snap_addr  <= '0;
            r_snap_wdata <= '0;
            r_snap_wstrb <= '0;
        end else begin
            r_pend <= w_stall;
            if (w_stall && !r_pend) begin
                r_snap_instr <= mem_instr;
                r_snap_addr  <= mem_addr;
                r_snap_wdata <= mem_wdata;
                r_snap_wstrb <= mem_wstrb;
            end
        end
    end

    // Sticky protocol and counter-sanity error flags.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err_unstable <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (r_pend && w_changed)
                err_unstable <= 1'b1;
            if (w_stall && r_wait == MAXW)
                err_timeout <= 1'b1;
        end
    end

endmodule
